// File: rtl/rs_key_pkg.sv
// Shared types for the RS key conditioner.
// Holds the per-key debounce FSM states and the synchroniser depth.
package rs_key_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      PRESSED   = 2'd2,
      RELEASING = 2'd3
   } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One key lane: a two-flop synchroniser, a debounce FSM with a saturating stability
// counter, and a single-cycle press strobe when a rising level is accepted.
module key_debounce_ch
   import rs_key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic level,
   output logic press_pulse_c
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   key_state_e             state_q;
   key_state_e             state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   // Metastability filter for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // State, counter and debounced level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         level   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level   <= (state_d == PRESSED) || (state_d == RELEASING);
      end
   end

   // Next-state logic; the counter only ever compares against its last value.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      press_pulse_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync) begin
               state_d = ARMING;
               cnt_d   = '0;
            end
         end
         ARMING: begin
            if (!sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = PRESSED;
               cnt_d         = '0;
               press_pulse_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!sync) begin
               state_d = RELEASING;
               cnt_d   = '0;
            end
         end
         RELEASING: begin
            if (sync) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/rs_key_conditioner.sv
// Front end for the RS flip-flop stage: debounces both keys and arbitrates their
// press strobes into registered s/r pulses, never issuing s and r together.
module rs_key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_set,
   input  logic key_rst,
   output logic s,
   output logic r,
   output logic set_level,
   output logic rst_level,
   output logic conflict
);

   logic set_press_c;
   logic rst_press_c;

   key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_set_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .key           (key_set),
      .level         (set_level),
      .press_pulse_c (set_press_c)
   );

   key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_rst_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .key           (key_rst),
      .level         (rst_level),
      .press_pulse_c (rst_press_c)
   );

   // Simultaneous accepted presses cancel each other and are reported instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s        <= 1'b0;
         r        <= 1'b0;
         conflict <= 1'b0;
      end else begin
         s        <= set_press_c & ~rst_press_c;
         r        <= rst_press_c & ~set_press_c;
         conflict <= set_press_c & rst_press_c;
      end
   end

endmodule

// File: tb/tb_rs_key_conditioner.sv
// Scoreboard bench for rs_key_conditioner: a run-length reference model predicts
// the outputs each cycle, directed scenarios check latency, counts and invariants.
module tb_rs_key_conditioner;

   localparam int unsigned DC = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic key_set;
   logic key_rst;
   logic s;
   logic r;
   logic set_level;
   logic rst_level;
   logic conflict;

   rs_key_conditioner #(
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_set   (key_set),
      .key_rst   (key_rst),
      .s         (s),
      .r         (r),
      .set_level (set_level),
      .rst_level (rst_level),
      .conflict  (conflict)
   );

   always #50 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] outs();
      return {s, r, conflict, set_level, rst_level};
   endfunction

   // Reference model: raw key seen two edges late; the level flips once DC+1
   // consecutive samples disagree with it, and a 0->1 flip is a press.
   logic [4:0]  exp_q[$];
   bit          m_p1  [2];
   bit          m_p2  [2];
   bit          m_lvl [2];
   int unsigned m_run [2];

   function automatic void model_clear();
      for (int k = 0; k < 2; k++) begin
         m_p1[k]  = 1'b0;
         m_p2[k]  = 1'b0;
         m_lvl[k] = 1'b0;
         m_run[k] = 0;
      end
   endfunction

   function automatic logic [4:0] model_step(input bit raw_set, input bit raw_rst);
      bit raw   [2];
      bit press [2];
      bit smp;
      raw[0] = raw_set;
      raw[1] = raw_rst;
      for (int k = 0; k < 2; k++) begin
         smp      = m_p2[k];
         m_p2[k]  = m_p1[k];
         m_p1[k]  = raw[k];
         press[k] = 1'b0;
         if (smp != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == DC + 1) begin
               m_lvl[k] = smp;
               m_run[k] = 0;
               press[k] = smp;
            end
         end else begin
            m_run[k] = 0;
         end
      end
      return {press[0] && !press[1], press[1] && !press[0], press[0] && press[1],
              m_lvl[0], m_lvl[1]};
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         model_clear();
         exp_q.push_back(5'b0);
      end else begin
         exp_q.push_back(model_step(key_set, key_rst));
      end
   end

   // An asynchronous reset overrides whatever was predicted for the current cycle.
   always @(negedge rst_n) begin
      model_clear();
      if (exp_q.size() != 0) exp_q[exp_q.size()-1] = 5'b0;
   end

   // Monitor: compare DUT outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      logic [4:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("scoreboard {s,r,conflict,set_level,rst_level}", outs(), e);
      end
   end

   // Pulse counters and invariants: no s&r, no pulse wider than one cycle.
   int unsigned cnt_s = 0;
   int unsigned cnt_r = 0;
   int unsigned cnt_c = 0;
   logic prev_s = 1'b0;
   logic prev_r = 1'b0;
   logic prev_c = 1'b0;

   always @(negedge clk) begin
      if (s)        cnt_s++;
      if (r)        cnt_r++;
      if (conflict) cnt_c++;
      check("invariant {s&r,s_wide,r_wide,conflict_wide}",
            {28'b0, s & r, prev_s & s, prev_r & r, prev_c & conflict}, 32'b0);
      prev_s = s;
      prev_r = r;
      prev_c = conflict;
   end

   int unsigned base_s, base_r, base_c;

   task automatic snap();
      base_s = cnt_s;
      base_r = cnt_r;
      base_c = cnt_c;
   endtask

   task automatic check_counts(input string name, input int unsigned es,
                               input int unsigned er, input int unsigned ec);
      check({name, " s_pulses"}, cnt_s - base_s, es);
      check({name, " r_pulses"}, cnt_r - base_r, er);
      check({name, " conflict_pulses"}, cnt_c - base_c, ec);
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Edges counted from the first edge that samples the new key value; 0 = timeout.
   task automatic measure(input bit is_set, output int unsigned lat);
      bit seen;
      lat  = 0;
      seen = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (!seen) begin
            @(posedge clk);
            #1;
            if (is_set ? s : r) begin
               lat  = k;
               seen = 1'b1;
            end
         end
      end
   endtask

   int unsigned lat;
   int unsigned lows;

   initial begin
      rst_n   = 1'b0;
      key_set = 1'b0;
      key_rst = 1'b0;
      cycles(3);
      check("reset_state", outs(), 5'b0);
      rst_n = 1'b1;
      cycles(2);

      // Clean set press
      snap();
      key_set = 1'b1;
      measure(1'b1, lat);
      check("clean_set_latency", lat, DC + 3);
      cycles(5);
      check("clean_set_level_held", set_level, 1'b1);
      key_set = 1'b0;
      cycles(15);
      check("clean_set_level_released", set_level, 1'b0);
      check_counts("clean", 1, 0, 0);

      // Bounce rejection
      snap();
      repeat (3) begin
         key_set = 1'b1;
         cycles(2);
         key_set = 1'b0;
         cycles(1);
      end
      check_counts("bounce_toggling", 0, 0, 0);
      key_set = 1'b1;
      measure(1'b1, lat);
      check("bounce_final_latency", lat, DC + 3);
      cycles(3);
      check_counts("bounce", 1, 0, 0);
      key_set = 1'b0;
      cycles(15);

      // Simultaneous press
      snap();
      key_set = 1'b1;
      key_rst = 1'b1;
      cycles(12);
      check("simul_levels", {set_level, rst_level}, 2'b11);
      key_set = 1'b0;
      key_rst = 1'b0;
      cycles(15);
      check_counts("simul", 0, 0, 1);

      // Reset press while set is held
      snap();
      key_set = 1'b1;
      cycles(12);
      key_rst = 1'b1;
      cycles(12);
      check("seq_levels", {set_level, rst_level}, 2'b11);
      check_counts("sequential", 1, 1, 0);
      key_set = 1'b0;
      key_rst = 1'b0;
      cycles(15);

      // Release glitch while pressed
      snap();
      key_set = 1'b1;
      cycles(12);
      key_set = 1'b0;
      cycles(2);
      key_set = 1'b1;
      lows = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (!set_level) lows++;
      end
      check("glitch_level_low_cycles", lows, 0);
      check_counts("glitch", 1, 0, 0);
      key_set = 1'b0;
      cycles(15);

      // Reset while key_rst is mid-count
      snap();
      key_set = 1'b1;
      cycles(12);
      key_rst = 1'b1;
      repeat (5) @(posedge clk);
      #10;
      check("pre_reset_set_level", set_level, 1'b1);
      rst_n   = 1'b0;
      key_set = 1'b0;
      #1;
      check("async_reset_outputs", outs(), 5'b0);
      #29;
      rst_n = 1'b1;
      measure(1'b0, lat);
      check("post_reset_r_latency", lat, DC + 3);
      cycles(3);
      check_counts("reset_mid", 1, 1, 0);
      key_rst = 1'b0;
      cycles(15);

      // Randomised key activity with occasional resets
      for (int i = 0; i < 300; i++) begin
         key_set = 1'($urandom_range(0, 1));
         key_rst = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 24) == 0) begin
            #10 rst_n = 1'b0;
            #20 rst_n = 1'b1;
         end
         cycles($urandom_range(1, 12));
      end
      key_set = 1'b0;
      key_rst = 1'b0;
      cycles(15);
      check("final_levels", {set_level, rst_level}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
